// File: rtl/lutram_sync_fifo_pkg.sv
// Shared types and elaboration-time helpers for the LUTRAM-backed FWFT FIFO.
package lutram_sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } status_t;

  localparam status_t STATUS_RESET = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

  function automatic bit depth_ok(input int depth, input int addr_w);
    return (depth >= 4) && (depth == (1 << addr_w)) && (clog2(depth) == addr_w);
  endfunction

  function automatic bit thresh_ok(input int aempty, input int afull, input int depth);
    return (aempty > 0) && (aempty < afull) && (afull < depth);
  endfunction

endpackage

// File: rtl/lutram_sync_fifo_lutram.sv
// LUTRAM storage primitive: registered write port, zero-latency asynchronous read port.
module lutram_sync_fifo_lutram #(
  parameter int pBuffDepth = 256,
  parameter int pBitWidth  = 32,
  parameter int pAddrWidth = 8
) (
  input  logic                  iCLK,
  input  logic                  iWEN,
  input  logic [pAddrWidth-1:0] iWADDR,
  input  logic [pBitWidth-1:0]  iWDATA,
  input  logic [pAddrWidth-1:0] iRADDR,
  output logic [pBitWidth-1:0]  oRDATA
);

  logic [pBitWidth-1:0] mem [pBuffDepth];

  always_ff @(posedge iCLK) begin
    if (iWEN) begin
      mem[iWADDR] <= iWDATA;
    end
  end

  assign oRDATA = mem[iRADDR];

endmodule

// File: rtl/lutram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO controller around the LUTRAM primitive.
module lutram_sync_fifo
  import lutram_sync_fifo_pkg::*;
#(
  parameter int pBuffDepth    = 256,
  parameter int pBitWidth     = 32,
  parameter int pAddrWidth    = 8,
  parameter int pAFullThresh  = 240,
  parameter int pAEmptyThresh = 16
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [pBitWidth-1:0]  iWD,
  input  logic                  iWE,
  input  logic                  iRE,
  input  logic                  iFlagClr,
  output logic [pBitWidth-1:0]  oRD,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAFull,
  output logic                  oAEmpty,
  output logic [pAddrWidth:0]   oCount,
  output logic                  oOvf,
  output logic                  oUdf
);

  localparam int AW = pAddrWidth;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(pBuffDepth);
  localparam logic [AW:0]   AFULL_C   = (AW+1)'(pAFullThresh);
  localparam logic [AW:0]   AEMPTY_C  = (AW+1)'(pAEmptyThresh);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  if (!depth_ok(pBuffDepth, pAddrWidth)) begin : g_bad_depth
    $error("lutram_sync_fifo: pBuffDepth must be a power of two >= 4 equal to 2**pAddrWidth");
  end
  if (!thresh_ok(pAEmptyThresh, pAFullThresh, pBuffDepth)) begin : g_bad_thresh
    $error("lutram_sync_fifo: thresholds must satisfy 0 < AEmpty < AFull < depth");
  end

  logic          wacc;
  logic          racc;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_next;
  status_t       stat_q;
  status_t       stat_next;
  logic          ovf_q;
  logic          udf_q;

  // A full FIFO can always pop and an empty one can always push, so gating on
  // the registered flags resolves the simultaneous-request corner cases.
  assign wacc = iWE & ~stat_q.full;
  assign racc = iRE & ~stat_q.empty;
  assign count_next = count_q + {{AW{1'b0}}, wacc} - {{AW{1'b0}}, racc};

  always_comb begin
    stat_next        = STATUS_RESET;
    stat_next.full   = (count_next == DEPTH_C);
    stat_next.empty  = (count_next == '0);
    stat_next.afull  = (count_next >= AFULL_C);
    stat_next.aempty = (count_next <= AEMPTY_C);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      stat_q  <= STATUS_RESET;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wacc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (racc) begin
        rptr <= rptr + PTR_ONE;
      end
      count_q <= count_next;
      stat_q  <= stat_next;
      // Set dominates clear when both happen in one cycle.
      ovf_q   <= (iWE & stat_q.full)  | (ovf_q & ~iFlagClr);
      udf_q   <= (iRE & stat_q.empty) | (udf_q & ~iFlagClr);
    end
  end

  lutram_sync_fifo_lutram #(
    .pBuffDepth (pBuffDepth),
    .pBitWidth  (pBitWidth),
    .pAddrWidth (pAddrWidth)
  ) u_lutram (
    .iCLK   (iCLK),
    .iWEN   (wacc),
    .iWADDR (wptr),
    .iWDATA (iWD),
    .iRADDR (rptr),
    .oRDATA (oRD)
  );

  assign oFull   = stat_q.full;
  assign oEmpty  = stat_q.empty;
  assign oAFull  = stat_q.afull;
  assign oAEmpty = stat_q.aempty;
  assign oCount  = count_q;
  assign oOvf    = ovf_q;
  assign oUdf    = udf_q;

endmodule
